// File: rtl/popcount_serial_n_if.sv
// Handshake bundle for popcount_serial_n.
// Master drives the request; slave returns status and result.
interface popcount_serial_n_if #(
  parameter int data_size = 8
);
  localparam int rw = $clog2(data_size + 1);

  logic                 start;
  logic [1:0]           mode;
  logic [data_size-1:0] in_data;
  logic                 busy;
  logic                 done;
  logic [rw-1:0]        result;

  modport master (
    output start, mode, in_data,
    input  busy, done, result
  );

  modport slave (
    input  start, mode, in_data,
    output busy, done, result
  );
endinterface

// File: rtl/popcount_serial_n.sv
// Bit-serial ones/zeros/trailing/leading-zero counter.
// Consumes bits_per_cycle bits per RUN cycle; may exit early.
module popcount_serial_n #(
  parameter int data_size      = 8,
  parameter int bits_per_cycle = 1,
  parameter bit early_exit     = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  popcount_serial_n_if.slave bus
);
  localparam int RW  = $clog2(data_size + 1);
  localparam int BPC = bits_per_cycle;
  localparam int NM  = data_size / bits_per_cycle;
  localparam int CW  = $clog2(NM + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [data_size-1:0] r_sh;
  logic [data_size-1:0] w_sh_nx;
  logic [RW-1:0]        r_acc;
  logic [RW-1:0]        r_result;
  logic [RW-1:0]        w_pop;
  logic [RW-1:0]        w_zc;
  logic [RW-1:0]        w_add;
  logic [1:0]           r_m;
  logic [CW-1:0]        r_cnt;
  logic                 r_found;
  logic                 r_busy;
  logic                 r_done;
  logic [BPC-1:0]       w_chunk;
  logic                 w_hit;
  logic                 w_exit;

  always_comb begin
    w_chunk = (r_m == 2'b11) ? r_sh[data_size-1 -: BPC]
                             : r_sh[BPC-1:0];
    w_sh_nx = (r_m == 2'b11) ? (r_sh << BPC) : (r_sh >> BPC);
    w_pop = '0;
    for (int i = 0; i < BPC; i++)
      w_pop = w_pop + RW'(w_chunk[i]);
    // zeros ahead of the first 1; BPC when the chunk is empty
    w_zc = RW'(BPC);
    if (r_m[0]) begin
      for (int i = 0; i < BPC; i++)
        if (w_chunk[i]) w_zc = RW'(BPC - 1 - i);
    end else begin
      for (int i = BPC - 1; i >= 0; i--)
        if (w_chunk[i]) w_zc = RW'(i);
    end
    w_hit = r_m[1] & (|w_chunk) & ~r_found;
    if (!r_m[1])     w_add = w_pop;
    else if (r_found) w_add = '0;
    else             w_add = w_zc;
    w_exit = (r_cnt + CW'(1) == CW'(NM))
      || (early_exit && !r_m[1] && (w_sh_nx == '0))
      || (early_exit && w_hit);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN:  if (w_exit)    w_next = S_DONE;
      S_DONE:                w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sh     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_sh    <= (bus.mode == 2'b01) ? ~bus.in_data : bus.in_data;
      r_m     <= bus.mode;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_found <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sh    <= w_sh_nx;
      r_acc   <= r_acc + w_add;
      r_cnt   <= r_cnt + CW'(1);
      r_found <= r_found | w_hit;
      if (w_exit) r_result <= r_acc + w_add;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_popcount_serial_n.sv
// Scoreboard bench for popcount_serial_n.
// Three instances cover chunk width and early-exit variants.
module tb_popcount_serial_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st[3];
  logic [1:0] md[3];
  logic [7:0] dt[3];
  logic       bz[3];
  logic       dn[3];
  logic [3:0] rs[3];

  popcount_serial_n_if #(.data_size(8)) if0 ();
  popcount_serial_n_if #(.data_size(8)) if1 ();
  popcount_serial_n_if #(.data_size(8)) if2 ();

  assign if0.start = st[0];
  assign if0.mode = md[0];
  assign if0.in_data = dt[0];
  assign if1.start = st[1];
  assign if1.mode = md[1];
  assign if1.in_data = dt[1];
  assign if2.start = st[2];
  assign if2.mode = md[2];
  assign if2.in_data = dt[2];
  assign bz[0] = if0.busy;
  assign dn[0] = if0.done;
  assign rs[0] = if0.result;
  assign bz[1] = if1.busy;
  assign dn[1] = if1.done;
  assign rs[1] = if1.result;
  assign bz[2] = if2.busy;
  assign dn[2] = if2.done;
  assign rs[2] = if2.result;

  popcount_serial_n #(
    .data_size(8), .bits_per_cycle(1), .early_exit(1'b1)
  ) u0 (.clock(clk), .reset(rst_n), .bus(if0.slave));
  popcount_serial_n #(
    .data_size(8), .bits_per_cycle(2), .early_exit(1'b1)
  ) u1 (.clock(clk), .reset(rst_n), .bus(if1.slave));
  popcount_serial_n #(
    .data_size(8), .bits_per_cycle(2), .early_exit(1'b0)
  ) u2 (.clock(clk), .reset(rst_n), .bus(if2.slave));

  typedef struct {
    int         dut;
    logic [3:0] res;
    int         n;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  int         cyc[3];
  logic [3:0] last[3];
  exp_t       e;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        cyc[k] = 0;
        last[k] = '0;
      end else begin
        if (bz[k]) cyc[k]++;
        if (dn[k]) begin
          chk($sformatf("busy_in_done_dut%0d", k), bz[k], 1);
          if (q.size() == 0) begin
            chk($sformatf("unexpected_done_dut%0d", k), 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("%s_dut", e.nm), k, e.dut);
            chk($sformatf("%s_result", e.nm), rs[k], e.res);
            chk($sformatf("%s_N", e.nm), cyc[k] - 1, e.n);
          end
          cyc[k] = 0;
          last[k] = rs[k];
        end else if (rs[k] != last[k]) begin
          chk($sformatf("result_stable_dut%0d", k), rs[k], last[k]);
          last[k] = rs[k];
        end
      end
    end
  end

  task automatic push(int k, logic [3:0] r, int n, string nm);
    exp_t x;
    x.dut = k;
    x.res = r;
    x.n = n;
    x.nm = nm;
    q.push_back(x);
  endtask

  task automatic wait_done(int k);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!dn[k] && t < 40);
    if (!dn[k]) chk($sformatf("timeout_dut%0d", k), 0, 1);
  endtask

  task automatic run(int k, logic [1:0] m, logic [7:0] d,
                     logic [3:0] r, int n, string nm);
    @(negedge clk);
    st[k] = 1'b1;
    md[k] = m;
    dt[k] = d;
    push(k, r, n, nm);
    @(posedge clk);
    #1;
    st[k] = 1'b0;
    md[k] = ~m;
    dt[k] = ~d;
    wait_done(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      md[k] = 2'b00;
      dt[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy_%0d", k), bz[k], 0);
      chk($sformatf("rst_done_%0d", k), dn[k], 0);
      chk($sformatf("rst_result_%0d", k), rs[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 2'b00, 8'h0B, 4'd3, 4, "ones_0B");
    run(0, 2'b01, 8'h0B, 4'd5, 8, "zeros_0B");
    run(0, 2'b10, 8'h28, 4'd3, 4, "tz_28");
    run(0, 2'b11, 8'h28, 4'd2, 3, "lz_28");
    run(0, 2'b00, 8'h00, 4'd0, 1, "ones_00");
    run(0, 2'b10, 8'h00, 4'd8, 8, "tz_00");
    run(0, 2'b01, 8'h00, 4'd8, 8, "zeros_00");
    run(1, 2'b00, 8'hFF, 4'd8, 4, "b2_ones_FF");
    run(1, 2'b11, 8'h28, 4'd2, 2, "b2_lz_28");
    run(1, 2'b10, 8'h28, 4'd3, 2, "b2_tz_28");
    run(2, 2'b11, 8'h28, 4'd2, 4, "b2_noee_lz_28");
    run(2, 2'b00, 8'h0B, 4'd3, 4, "b2_noee_ones_0B");

    // start held high: one IDLE cycle between runs
    @(negedge clk);
    st[0] = 1'b1;
    md[0] = 2'b00;
    dt[0] = 8'h0B;
    for (int i = 0; i < 3; i++) push(0, 4'd3, 4, $sformatf("hold%0d", i));
    for (int i = 0; i < 3; i++) begin
      wait_done(0);
      @(negedge clk);
      chk($sformatf("hold_idle%0d", i), bz[0], 0);
      if (i == 2) begin
        st[0] = 1'b0;
      end else begin
        @(negedge clk);
        chk($sformatf("hold_rerun%0d", i), bz[0], 1);
      end
    end

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    st[0] = 1'b1;
    md[0] = 2'b10;
    dt[0] = 8'h28;
    push(0, 4'd3, 4, "pulse_tz_28");
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b1;
    md[0] = 2'b00;
    dt[0] = 8'hFF;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("no_extra_run", bz[0], 0);
    end

    // asynchronous reset in RUN cycle 2
    @(negedge clk);
    st[0] = 1'b1;
    md[0] = 2'b00;
    dt[0] = 8'hFF;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bz[0], 0);
    chk("mid_rst_done", dn[0], 0);
    chk("mid_rst_result", rs[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_done_after_rst", dn[0], 0);
    end
    run(0, 2'b00, 8'hFF, 4'd8, 8, "post_rst_FF");

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/popcount_serial_n.md
# popcount_serial_n

Parametrised bit-serial bit-statistics unit, the next generation of the datapath's start/ready shift-and-count engine. It loads a `data_size`-bit operand on `start` and processes `bits_per_cycle` bits per clock. It returns one of four counts: ones, zeros, trailing zeros, or leading zeros. Runs end early once the answer is fixed. The unit sits beside the existing arithmetic engines and uses the same start/ready-style handshake, plus an explicit `busy` output and a `done` pulse.

## Interface
- `data_size`, default 8: operand width, ≥ 2.
- `bits_per_cycle`, default 1: bits consumed per RUN cycle. Must divide `data_size`.
- `early_exit`, default 1: 1 enables early termination; 0 forces full-length runs.
- Derived, not overridable: `rw = $clog2(data_size+1)`, the result width. `N_MAX = data_size/bits_per_cycle`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `mode` in 2: 00 count ones, 01 count zeros, 10 trailing zeros (from LSB), 11 leading zeros (from MSB). Sampled with `start`.
- `in_data` in `data_size`: operand; sampled with `start`.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse in DONE.
- `result` out `rw`: last completed count; held until the next DONE.

## Operation
- **Registers:** shift register `sh` (`data_size`), accumulator `acc` (`rw`), latched mode `m`, chunk counter (`$clog2(N_MAX+1)` bits), output register `result`.
- **States:** IDLE, RUN, DONE.
  - IDLE with `start=1`: load `sh` and `m`, clear `acc` and the chunk counter, go to RUN.
  - Load value of `sh`: `~in_data` for mode 01, otherwise `in_data`. Mode 01 then executes exactly as mode 00.
  - IDLE with `start=0`: stay.
- **RUN, per cycle,** on chunk `c`:
  - Chunk selection: modes 00/01/10 take the low `bits_per_cycle` bits of `sh` and shift right. Mode 11 takes the high bits and shifts left. Zeros are shifted in.
  - Modes 00/01: `acc += popcount(c)`.
  - Modes 10/11: if `c` is all zero, `acc += bits_per_cycle`. Otherwise add the number of zeros preceding the first 1, scanning from the LSB side for 10 or the MSB side for 11, and mark the run finished.
  - Exit to DONE when any of the following holds:
    - the chunk counter reaches `N_MAX`;
    - `early_exit=1` and the shifted `sh == 0` (modes 00/01);
    - `early_exit=1` and a 1 was found (modes 10/11).
  - With `early_exit=0`, modes 10/11 still stop adding after the first 1, but always run `N_MAX` cycles.
- **DONE:** `result <= acc` (written on the RUN→DONE edge, visible in the DONE cycle). `done=1`, then go to IDLE unconditionally. `start` in DONE is ignored.
- **Arithmetic:** `acc` never exceeds `data_size`, so `rw` bits never overflow.
- **Reset (async, `reset=0`):** state=IDLE, `sh=0`, `acc=0`, `result=0`, `busy=0`, `done=0`. Reset mid-RUN aborts the run, with no `done` pulse and `result` forced to 0.

## Timing
- Let E0 be the edge at which IDLE samples `start=1`. RUN occupies cycles 1..N after E0, with 1 ≤ N ≤ `N_MAX`. DONE is cycle N+1, with `done=1`, `busy=1`, and the new `result` valid. Cycle N+2 is IDLE, where the earliest next `start` is accepted.
- Latency from the `start` edge to the `done` cycle is N+1 cycles. Back-to-back throughput is one operation per N+2 cycles.
- Changes to `in_data`/`mode` after E0 do not affect the current run.
- `busy` is registered. It is low only in IDLE.

## Test plan
- **Ones, early exit** (`data_size=8`, `bits_per_cycle=1`, `early_exit=1`): `in_data=8'h0B`, mode 00 → N=4, `done` in cycle 5, `result=3`. Then mode 01 with the same data → `~data=8'hF4`, N=8, `result=5`.
- **Trailing/leading zeros, `bits_per_cycle=1`:** `8'h28`, mode 10 → N=4, `result=3`. Mode 11 → N=3, `result=2`.
- **All-zero operand:** `8'h00`, mode 00 → N=1, `result=0`. Mode 10 → N=8, `result=8`. Mode 01 → N=8, `result=8`.
- **Wide chunks, `bits_per_cycle=2`:** `8'hFF`, mode 00 → N=4, `result=8`. `8'h28`, mode 11 → N=2, `result=2`. With `early_exit=0`, `8'h28`, mode 11 → N=4, `result=2`.
- **Handshake:**
  - Hold `start=1` continuously: runs repeat with exactly one IDLE cycle between each `done` and the next RUN.
  - Pulse `start` during RUN or DONE: ignored, no extra run.
  - `result` stays stable between `done` pulses.
- **Reset mid-RUN:** assert `reset=0` asynchronously in RUN cycle 2 of an `8'hFF` mode 00 run. `busy`, `done`, and `result` go to 0 immediately, without waiting for a clock edge. No `done` pulse follows. After release, a new `start` runs normally.
